// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog register block.
// Holds the register offsets, the WTOCNT reset value, the STATUS bit
// positions, the bus request record and the handshake FSM state encoding.
package wdt_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_LIVE   = 8'h04;
    localparam logic [7:0] OFF_WTOCNT = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;
    localparam logic [7:0] OFF_IRQEN  = 8'h10;

    localparam logic [31:0] WTOCNT_RST = 32'hFFFF_FFFF;

    localparam int STATUS_STICKY_BIT = 0;
    localparam int STATUS_WTO_BIT    = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    typedef struct packed {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/wdt_regfile_if.sv
// Request/response bus between a host and the watchdog register block.
// master: issues requests, consumes responses.
// slave : accepts requests (req_ready), returns rsp_valid/rsp_rdata/rsp_err.
interface wdt_regfile_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/wdt_top.sv
// Watchdog subsystem: register file plus the down-counter it controls.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of the register bus
//   irq      - timeout interrupt from the register file
// The counter reloads from WTOCNT while disabled or on a kick, counts down
// while enabled, and raises WTO on reaching zero. WTO_write pulses the cycle
// after WTO changes so the register file can latch the sticky status.
module wdt_top
    import wdt_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    wdt_regfile_if.slave  bus,
    output logic          irq
);

    logic        wden;
    logic        wdlive;
    logic [31:0] wtocnt;
    logic        wto;
    logic        wto_write;
    logic [31:0] cnt;

    wdt_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .WDEN      (wden),
        .WDLIVE    (wdlive),
        .WTOCNT    (wtocnt),
        .WTO       (wto),
        .WTO_write (wto_write),
        .irq       (irq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= WTOCNT_RST;
            wto       <= 1'b0;
            wto_write <= 1'b0;
        end else begin
            wto_write <= 1'b0;
            if (!wden || wdlive) begin
                cnt <= wtocnt;
                if (wto) begin
                    wto       <= 1'b0;
                    wto_write <= 1'b1;
                end
            end else if (cnt != 32'd0) begin
                cnt <= cnt - 32'd1;
            end else if (!wto) begin
                wto       <= 1'b1;
                wto_write <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wdt_regfile.sv
// Watchdog control/status register file.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   bus        - slave side of the request/response bus (one outstanding access)
//   WDEN       - watchdog enable (CTRL bit0)
//   WDLIVE     - one-cycle kick pulse after a write to LIVE
//   WTOCNT     - timeout reload count
//   WTO        - timeout level from the watchdog counter
//   WTO_write  - WTO changed last cycle
//   irq        - registered sticky-timeout & IRQEN interrupt
module wdt_regfile
    import wdt_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    wdt_regfile_if.slave   bus,
    output logic           WDEN,
    output logic           WDLIVE,
    output logic [31:0]    WTOCNT,
    input  logic           WTO,
    input  logic           WTO_write,
    output logic           irq
);

    localparam logic [0:0] IDLE = ST_IDLE;
    localparam logic [0:0] RESP = ST_RESP;

    logic [0:0]  state;
    logic        sticky;
    logic        irqen;
    logic [31:0] rdata_q;
    logic        err_q;

    req_t        req;
    logic        accept;
    logic        hit_ctrl, hit_live, hit_cnt, hit_status, hit_irqen, mapped;
    logic [31:0] rd_val;
    logic        rd_err;
    logic        wr_ok;
    logic        sticky_set, sticky_clr;

    assign req = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};

    // Not ready while reset is held, even though the state is already IDLE.
    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    assign accept = bus.req_valid && bus.req_ready;

    // Exact 8-bit compares: any misaligned offset misses every register.
    assign hit_ctrl   = (req.addr == OFF_CTRL);
    assign hit_live   = (req.addr == OFF_LIVE);
    assign hit_cnt    = (req.addr == OFF_WTOCNT);
    assign hit_status = (req.addr == OFF_STATUS);
    assign hit_irqen  = (req.addr == OFF_IRQEN);
    assign mapped     = hit_ctrl | hit_live | hit_cnt | hit_status | hit_irqen;

    // Response contents for the access being accepted. Writes return 0;
    // reads see register values from before this edge's updates.
    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        if (!mapped) begin
            rd_err = 1'b1;
        end else if (req.write) begin
            // WTOCNT is locked while the watchdog runs.
            rd_err = hit_cnt && WDEN;
        end else begin
            if (hit_ctrl)  rd_val[0] = WDEN;
            if (hit_cnt)   rd_val    = WTOCNT;
            if (hit_status) begin
                rd_val[STATUS_STICKY_BIT] = sticky;
                rd_val[STATUS_WTO_BIT]    = WTO;
            end
            if (hit_irqen) rd_val[0] = irqen;
        end
    end

    assign wr_ok      = accept && req.write && !rd_err;
    assign sticky_set = WTO_write && WTO;
    assign sticky_clr = wr_ok && hit_status && req.wdata[STATUS_STICKY_BIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            WDEN    <= 1'b0;
            WDLIVE  <= 1'b0;
            WTOCNT  <= WTOCNT_RST;
            sticky  <= 1'b0;
            irqen   <= 1'b0;
            irq     <= 1'b0;
        end else begin
            WDLIVE <= wr_ok && hit_live;
            // Set wins over a simultaneous clear.
            sticky <= sticky_set | (sticky & ~sticky_clr);
            irq    <= sticky & irqen;

            if (wr_ok && hit_ctrl)  WDEN   <= req.wdata[0];
            if (wr_ok && hit_cnt)   WTOCNT <= req.wdata;
            if (wr_ok && hit_irqen) irqen  <= req.wdata[0];

            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= RESP;
                        rdata_q <= rd_val;
                        err_q   <= rd_err;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
